// File: rtl/tile_dma_pkg.sv
// tile_dma_pkg: shared FSM state encoding and memory beat geometry for tile_dma_ctrl.
package tile_dma_pkg;
  localparam int MEM_BEAT_W = 64;
  localparam int ROW_BYTES  = 8;
  typedef enum logic [3:0] {
    IDLE,
    RD_A,
    PUSH_A,
    RD_B,
    PUSH_B,
    WAIT_C,
    WR_LO,
    WR_HI,
    DONE
  } state_e;
endpackage

// File: rtl/tile_dma_ctrl.sv
// tile_dma_ctrl: streams A rows / B columns from memory into the array and writes result rows back.
// Optional TILE_DMA_PERF_EN adds a saturating memory-stall counter on perf_stall_cnt.
module tile_dma_ctrl
  import tile_dma_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           a_base,
  input  logic [31:0]           b_base,
  input  logic [31:0]           c_base,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [31:0]           mem_addr,
  input  logic [MEM_BEAT_W-1:0] mem_rdata,
  output logic [MEM_BEAT_W-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  a_valid,
  input  logic                  a_ready,
  output logic [N*8-1:0]        a_row,
  output logic                  b_valid,
  input  logic                  b_ready,
  output logic [N*8-1:0]        b_col,
  input  logic                  c_valid,
  output logic                  c_ready,
  input  logic [N*16-1:0]       c_row,
  output logic [31:0]           perf_stall_cnt
);
  localparam int IW = $clog2(N) + 1;
  if (N != 8) begin : g_bad_n
    $error("tile_dma_ctrl: N must be 8");
  end
  state_e          state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic            pend_q, pend_d;
  logic [31:0]     a_base_q, b_base_q, c_base_q;
  logic [N*8-1:0]  a_row_q, a_row_d, b_col_q, b_col_d;
  logic [N*16-1:0] c_row_q, c_row_d;
  logic            accept;
  logic [IW-1:0]   i_nx;
  logic            last;
  logic [31:0]     off8, off16;
  assign i_nx  = i_q + 1'b1;
  assign last  = (i_nx == IW'(N));
  assign off8  = 32'(i_q) << 3;
  assign off16 = 32'(i_q) << 4;
  assign a_row = a_row_q;
  assign b_col = b_col_q;
  assign busy  = (state_q != IDLE) && (state_q != DONE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      i_q      <= '0;
      pend_q   <= 1'b0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      a_row_q  <= '0;
      b_col_q  <= '0;
      c_row_q  <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      pend_q   <= pend_d;
      a_base_q <= accept ? a_base : a_base_q;
      b_base_q <= accept ? b_base : b_base_q;
      c_base_q <= accept ? c_base : c_base_q;
      a_row_q  <= a_row_d;
      b_col_q  <= b_col_d;
      c_row_q  <= c_row_d;
    end
  end
  // Reads take two phases: request until grant, then one pend cycle to capture rdata.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    pend_d    = pend_q;
    a_row_d   = a_row_q;
    b_col_d   = b_col_q;
    c_row_d   = c_row_q;
    accept    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    c_ready   = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        accept  = start;
        i_d     = start ? '0 : i_q;
        pend_d  = 1'b0;
        state_d = start ? RD_A : IDLE;
      end
      RD_A: begin
        mem_addr = a_base_q + off8;
        mem_req  = !pend_q;
        a_row_d  = pend_q ? mem_rdata : a_row_q;
        pend_d   = pend_q ? 1'b0 : mem_gnt;
        state_d  = pend_q ? PUSH_A : RD_A;
      end
      PUSH_A: begin
        a_valid = 1'b1;
        i_d     = a_ready ? (last ? '0 : i_nx) : i_q;
        state_d = a_ready ? (last ? RD_B : RD_A) : PUSH_A;
      end
      RD_B: begin
        mem_addr = b_base_q + off8;
        mem_req  = !pend_q;
        b_col_d  = pend_q ? mem_rdata : b_col_q;
        pend_d   = pend_q ? 1'b0 : mem_gnt;
        state_d  = pend_q ? PUSH_B : RD_B;
      end
      PUSH_B: begin
        b_valid = 1'b1;
        i_d     = b_ready ? (last ? '0 : i_nx) : i_q;
        state_d = b_ready ? (last ? WAIT_C : RD_B) : PUSH_B;
      end
      WAIT_C: begin
        c_ready = 1'b1;
        c_row_d = c_valid ? c_row : c_row_q;
        state_d = c_valid ? WR_LO : WAIT_C;
      end
      WR_LO: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = c_base_q + off16;
        mem_wdata = c_row_q[MEM_BEAT_W-1:0];
        state_d   = mem_gnt ? WR_HI : WR_LO;
      end
      WR_HI: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = c_base_q + off16 + 32'(ROW_BYTES);
        mem_wdata = c_row_q[2*MEM_BEAT_W-1:MEM_BEAT_W];
        i_d       = mem_gnt ? (last ? '0 : i_nx) : i_q;
        state_d   = mem_gnt ? (last ? DONE : WAIT_C) : WR_HI;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef TILE_DMA_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst || accept) stall_q <= '0;
    else if (mem_req && !mem_gnt && stall_q != '1) stall_q <= stall_q + 32'd1;
  end
  assign perf_stall_cnt = stall_q;
`else
  assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_tile_dma_ctrl.sv
// tb_tile_dma_ctrl: directed self-checking bench for tile_dma_ctrl with a simple memory/array model.
module tb_tile_dma_ctrl;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   a_base = '0, b_base = '0, c_base = '0;
  logic          busy, done, mem_req, mem_we, a_valid, b_valid, c_ready;
  logic          mem_gnt = 1'b1;
  logic [31:0]   mem_addr, perf_stall_cnt;
  logic [63:0]   mem_rdata = '0;
  logic [63:0]   mem_wdata, a_row, b_col;
  logic          a_ready = 1'b1, b_ready = 1'b1, c_valid = 1'b1;
  logic [127:0]  c_row;
  logic          clr = 1'b0;
  int            checks = 0, errors = 0;
  int            nr, nw, na, nb, nd, nx, nc;
  logic [31:0]   rd_addr[32];
  logic [31:0]   wr_addr[32];
  logic [63:0]   wr_data[32];
  logic [63:0]   a_rows[8];
  logic [63:0]   b_cols[8];
  localparam logic [127:0] C0 = 128'h0123456789ABCDEF_FEDCBA9889ABCDEF;
`ifdef TILE_DMA_PERF_EN
  localparam logic [127:0] PERF_EXP = 128'd5;
`else
  localparam logic [127:0] PERF_EXP = 128'd0;
`endif

  tile_dma_ctrl #(.N(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_base(a_base), .b_base(b_base), .c_base(c_base),
    .busy(busy), .done(done),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .a_valid(a_valid), .a_ready(a_ready), .a_row(a_row),
    .b_valid(b_valid), .b_ready(b_ready), .b_col(b_col),
    .c_valid(c_valid), .c_ready(c_ready), .c_row(c_row),
    .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  assign c_row = C0 + 128'(nc);

  always @(posedge clk) begin
    if (mem_req && mem_gnt && !mem_we) mem_rdata <= {~mem_addr, mem_addr};
    if (clr) nc <= 0;
    else if (c_valid && c_ready) nc <= nc + 1;
  end

  always @(negedge clk) begin
    if (clr) begin
      nr <= 0; nw <= 0; na <= 0; nb <= 0; nd <= 0; nx <= 0;
    end else begin
      if (mem_req && mem_gnt && mem_we && nw < 32) begin
        wr_addr[nw] <= mem_addr;
        wr_data[nw] <= mem_wdata;
        nw <= nw + 1;
      end
      if (mem_req && mem_gnt && !mem_we && nr < 32) begin
        rd_addr[nr] <= mem_addr;
        nr <= nr + 1;
      end
      if (a_valid && a_ready && na < 8) begin
        a_rows[na] <= a_row;
        na <= na + 1;
      end
      if (b_valid && b_ready && nb < 8) begin
        b_cols[nb] <= b_col;
        nb <= nb + 1;
      end
      if (done) nd <= nd + 1;
      if (32'(a_valid) + 32'(b_valid) + 32'(c_ready) + 32'(mem_req) > 1) nx <= nx + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_avalid"}, a_valid, 0);
    chk({tag, "_arow"}, a_row, 0);
    chk({tag, "_bvalid"}, b_valid, 0);
    chk({tag, "_bcol"}, b_col, 0);
    chk({tag, "_cready"}, c_ready, 0);
    chk({tag, "_perf"}, perf_stall_cnt, 0);
  endtask

  task automatic clear_logs();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic run_to_done(input string tag);
    for (int k = 0; k < 400 && !done; k++) step();
    chk({tag, "_done_seen"}, done, 1);
    step();
    chk({tag, "_done_drop"}, done, 0);
    chk({tag, "_busy_drop"}, busy, 0);
  endtask

  initial begin
    start = 1'b1;
    clear_logs();
    step();
    start = 1'b0;
    rst = 1'b0;
    chk_idle("reset");

    a_base = 32'h1000; b_base = 32'h3000; c_base = 32'h2000;
    clear_logs();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("full_busy", busy, 1);
    run_to_done("full");
    chk("full_nreads", nr, 16);
    chk("full_rd0", rd_addr[0], 32'h1000);
    chk("full_rd7", rd_addr[7], 32'h1038);
    chk("full_rd8", rd_addr[8], 32'h3000);
    chk("full_na", na, 8);
    chk("full_arow1", a_rows[1], 64'hFFFFEFF7_00001008);
    chk("full_nb", nb, 8);
    chk("full_bcol0", b_cols[0], 64'hFFFFCFFF_00003000);
    chk("full_nwrites", nw, 16);
    chk("full_wr0_addr", wr_addr[0], 32'h2000);
    chk("full_wr0_data", wr_data[0], 64'hFEDCBA9889ABCDEF);
    chk("full_wr1_addr", wr_addr[1], 32'h2008);
    chk("full_wr1_data", wr_data[1], 64'h0123456789ABCDEF);
    chk("full_wr14_data", wr_data[14], 64'hFEDCBA9889ABCDF6);
    chk("full_wr15_addr", wr_addr[15], 32'h2078);
    chk("full_ndone", nd, 1);
    chk("full_exclusive", nx, 0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_gnt = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_req", mem_req, 1);
      chk("stall_addr", mem_addr, 32'h1000);
      step();
    end
    mem_gnt = 1'b1;
    step();
    step();
    chk("stall_perf", perf_stall_cnt, PERF_EXP);
    run_to_done("stall");
    chk("stall_perf_end", perf_stall_cnt, PERF_EXP);

    a_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 20 && !a_valid; k++) step();
    for (int k = 0; k < 3; k++) begin
      chk("aready_valid", a_valid, 1);
      chk("aready_row", a_row, 64'hFFFFEFFF_00001000);
      chk("aready_noreq", mem_req, 0);
      step();
    end
    a_ready = 1'b1;
    step();
    chk("aready_next_req", mem_req, 1);
    chk("aready_next_addr", mem_addr, 32'h1008);
    run_to_done("aready");

    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 200 && !(mem_req && mem_addr == 32'h3000); k++) step();
    chk("mid_in_rdb", mem_addr, 32'h3000);
    a_base = 32'h5000; c_base = 32'h6000;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("mid_busy", busy, 1);
    for (int k = 0; k < 400 && !mem_we; k++) step();
    chk("mid_wr_lo_addr", mem_addr, 32'h2000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("midrst");
    step();
    chk("midrst_still_idle", busy, 0);
    clear_logs();
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_done("fresh");
    chk("fresh_rd0", rd_addr[0], 32'h5000);
    chk("fresh_wr0", wr_addr[0], 32'h6000);
    chk("fresh_nwrites", nw, 16);
    chk("fresh_ndone", nd, 1);

    a_base = 32'hFFFF_FFF8;
    clear_logs();
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_done("wrap");
    chk("wrap_rd0", rd_addr[0], 32'hFFFF_FFF8);
    chk("wrap_rd1", rd_addr[1], 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tile_dma_ctrl.md
TILE_DMA_CTRL -- requirements
Module: tile_dma_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, array dimension; only N=8 legal (N*8 = 64-bit memory beat); elaboration assertion otherwise.
REQ-002 SHALL have clk  input  1  single clock, all logic rising-edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have start  input  1  one-cycle tile launch pulse.
REQ-005 SHALL have a_base, b_base, c_base  input  32 each  byte base addresses, sampled on accepted start.
REQ-006 SHALL have busy  output  1  tile in progress; done  output  1  one-cycle completion pulse.
REQ-007 SHALL have mem_req output 1, mem_gnt input 1, mem_addr output 32, mem_rdata input 64, mem_wdata output 64, mem_we output 1: shared memory port.
REQ-008 SHALL have a_valid output 1, a_ready input 1, a_row output N*8: A-row stream to array.
REQ-009 SHALL have b_valid output 1, b_ready input 1, b_col output N*8: B-column stream to array.
REQ-010 SHALL have c_valid input 1, c_ready output 1, c_row input N*16: result-row stream from array.
REQ-011 SHALL have perf_stall_cnt  output  32  memory stall counter (see Configuration).

Function
REQ-012 SHALL implement FSM IDLE -> RD_A -> PUSH_A -> (RD_A | RD_B) -> PUSH_B -> (RD_B | WAIT_C) -> WR_LO -> WR_HI -> (WAIT_C | DONE) -> IDLE.
REQ-013 SHALL accept start only in IDLE; start while busy SHALL be ignored with no state change.
REQ-014 SHALL, on accepted start, latch bases, clear row index i, enter RD_A, and assert busy from the next cycle until DONE exits.
REQ-015 SHALL, in RD_A, drive mem_req=1, mem_we=0, mem_addr=a_base+8*i, held stable until the mem_gnt cycle.
REQ-016 SHALL treat mem_rdata as valid exactly one cycle after mem_gnt and capture it into a_row; mem_req SHALL drop the cycle after gnt.
REQ-017 SHALL, in PUSH_A, hold a_valid=1 and a_row stable until a_valid&&a_ready; then i+1, returning to RD_A while i<N, else clear i and enter RD_B.
REQ-018 SHALL sequence RD_B/PUSH_B identically using b_base+8*i, b_col, b_valid/b_ready.
REQ-019 SHALL, in WAIT_C, drive c_ready=1 (only state where it is 1); on c_valid&&c_ready capture c_row, enter WR_LO.
REQ-020 SHALL, in WR_LO, write mem_wdata=c_row[63:0] to c_base+16*i; in WR_HI, c_row[127:64] to c_base+16*i+8; mem_we=1, mem_req held until gnt in each.
REQ-021 SHALL, after WR_HI grant, increment i and return to WAIT_C while i<N, else enter DONE.
REQ-022 SHALL, in DONE, pulse done=1 for one cycle, deassert busy, return to IDLE.
REQ-023 SHALL compute addresses modulo 2^32 (wrap silently); row index width clog2(N)+1.
REQ-024 SHALL never assert a_valid, b_valid, c_ready and mem_req in the same cycle; at most one is high.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, enter IDLE and drive next cycle: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, a_valid=0, a_row=0, b_valid=0, b_col=0, c_ready=0, busy=0, done=0, i=0.
REQ-026 SHALL abandon any in-flight memory request or stream transfer on reset mid-tile; a grant arriving the reset cycle SHALL be ignored.
REQ-027 SHALL give rst priority over start in the same cycle.

Configuration
REQ-028 SHALL, with TILE_DMA_PERF_EN defined, count cycles with mem_req=1 and mem_gnt=0 in perf_stall_cnt, cleared on accepted start and reset, saturating at 2^32-1.
REQ-029 SHALL, without TILE_DMA_PERF_EN, tie perf_stall_cnt to 0 and omit the counter logic.

Structure
REQ-030 SHALL place the FSM state enum, MEM_BEAT_W=64 and ROW_BYTES=8 in shared package tile_dma_pkg.
REQ-031 SHALL be a single module; no sub-module is required.

Verification
REQ-032 Full tile, gnt always 1, ready always 1, a_base=0x1000 -> A reads at 0x1000..0x1038 step 8, 8 A rows, 8 B rows, 16 writes, one done pulse.
REQ-033 c_base=0x2000, c_row=128'h0123..CDEF at i=0 -> writes low 64b at 0x2000, high 64b at 0x2008.
REQ-034 mem_gnt held 0 for 5 cycles on first read -> mem_addr/mem_req stable 5 cycles; perf_stall_cnt=5 with TILE_DMA_PERF_EN, 0 without.
REQ-035 a_ready low 3 cycles -> a_valid and a_row stable, no new mem_req until handshake.
REQ-036 start pulsed during RD_B; later rst asserted in WR_LO -> start ignored; after reset all outputs zero, busy=0, fresh start runs a complete tile.
REQ-037 a_base=0xFFFF_FFF8 -> second A read address 0x0000_0000.
